// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  fetch_sequencer : PC, fetch handshake, IR and flags ahead of control unit.
//  Optional: FETCH_RETIRE_COUNT_EN adds a 32-bit retire_count output.
//  Rev 1.0
// ============================================================================
module fetch_sequencer #(
  parameter int                ADDR_W      = 8,
  parameter int                INSTR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [4:0]        HALT_OPCODE = 5'b11111
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [4:0]         opcode,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               ex_ready,
  input  logic               is_jz,
  input  logic               is_jnz,
  input  logic               is_jl,
  input  logic               is_jg,
  input  logic               is_jump,
  input  logic               flags_write,
  input  logic               alu_zero,
  input  logic               alu_neg,
  input  logic               alu_pos,
  output logic               flag_z,
  output logic               flag_l,
  output logic               flag_g,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
`ifdef FETCH_RETIRE_COUNT_EN
  ,
  output logic [31:0]        retire_count
`endif
);

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    ISSUE      = 2'd2,
    HALTED     = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic                r_req;
  logic                r_valid;
  logic                r_halted;
  logic                r_flag_z;
  logic                r_flag_l;
  logic                r_flag_g;
  logic                w_taken;
  logic                w_is_halt;
`ifdef FETCH_RETIRE_COUNT_EN
  logic [31:0]         r_retire_count;
`endif

  // Branch decision always sees the flags from before the retiring instruction.
  assign w_taken   = is_jump | (is_jz & r_flag_z) | (is_jnz & ~r_flag_z)
                   | (is_jl & r_flag_l) | (is_jg & r_flag_g);
  assign w_is_halt = (r_ir[INSTR_W-1:INSTR_W-5] == HALT_OPCODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= FETCH_REQ;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_req    <= 1'b0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_l <= 1'b0;
      r_flag_g <= 1'b0;
`ifdef FETCH_RETIRE_COUNT_EN
      r_retire_count <= '0;
`endif
    end else begin
      case (r_state)
        FETCH_REQ: begin
          r_req   <= 1'b1;
          r_state <= FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (ex_ready) begin
            if (flags_write) begin
              r_flag_z <= alu_zero;
              r_flag_l <= alu_neg;
              r_flag_g <= alu_pos;
            end
            r_pc    <= w_taken ? r_ir[ADDR_W-1:0] : r_pc + ADDR_W'(1);
            r_valid <= 1'b0;
`ifdef FETCH_RETIRE_COUNT_EN
            r_retire_count <= r_retire_count + 32'd1;
`endif
            if (w_is_halt) begin
              r_halted <= 1'b1;
              r_state  <= HALTED;
            end else begin
              r_state  <= FETCH_REQ;
            end
          end
        end
        HALTED: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign opcode      = r_ir[INSTR_W-1:INSTR_W-5];
  assign instr       = r_ir;
  assign instr_valid = r_valid;
  assign flag_z      = r_flag_z;
  assign flag_l      = r_flag_l;
  assign flag_g      = r_flag_g;
  assign pc          = r_pc;
  assign halted      = r_halted;
`ifdef FETCH_RETIRE_COUNT_EN
  assign retire_count = r_retire_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  tb_fetch_sequencer : directed table, corner sequences and random traffic
//  against a behavioural model of fetch_sequencer.  Rev 1.0
// ============================================================================
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [4:0]  opcode;
  logic [15:0] instr;
  logic        instr_valid;
  logic        ex_ready = 1'b0;
  logic        is_jz = 1'b0, is_jnz = 1'b0, is_jl = 1'b0, is_jg = 1'b0, is_jump = 1'b0;
  logic        flags_write = 1'b0;
  logic        alu_zero = 1'b0, alu_neg = 1'b0, alu_pos = 1'b0;
  logic        flag_z, flag_l, flag_g;
  logic [7:0]  pc;
  logic        halted;
`ifdef FETCH_RETIRE_COUNT_EN
  logic [31:0] retire_count;
`endif

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .opcode(opcode), .instr(instr), .instr_valid(instr_valid), .ex_ready(ex_ready),
    .is_jz(is_jz), .is_jnz(is_jnz), .is_jl(is_jl), .is_jg(is_jg), .is_jump(is_jump),
    .flags_write(flags_write), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_pos(alu_pos),
    .flag_z(flag_z), .flag_l(flag_l), .flag_g(flag_g), .pc(pc), .halted(halted)
`ifdef FETCH_RETIRE_COUNT_EN
    , .retire_count(retire_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_pc;
  bit m_z, m_l, m_g;
  int m_count;

  typedef struct {
    logic [15:0] ins;
    int          lat;
    int          stall;
    logic [4:0]  jmp;     // {is_jump, is_jz, is_jnz, is_jl, is_jg}
    logic        fw;
    logic [2:0]  alu;     // {zero, neg, pos}
    logic [7:0]  exp_pc;
    logic [2:0]  exp_flags; // {z, l, g}
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_pc = 0; m_z = 0; m_l = 0; m_g = 0; m_count = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; imem_ack = 1'b0; ex_ready = 1'b0;
    repeat (2) step();
    model_reset();
    rst_n = 1'b1;
  endtask

  // Serve one fetch: wait for the request, check the address, ack after lat cycles.
  task automatic fetch(input logic [15:0] data, input int lat);
    int n = 0;
    while (imem_req !== 1'b1 && n < 10) begin step(); n++; end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", {24'd0, imem_addr}, m_pc[31:0] & 32'hFF);
    for (int i = 0; i < lat; i++) begin
      step();
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_held", {24'd0, imem_addr}, m_pc[31:0] & 32'hFF);
    end
    imem_ack = 1'b1; imem_rdata = data;
    step();
    imem_ack = 1'b0; imem_rdata = $urandom;
    chk("issue_valid", {31'd0, instr_valid}, 32'd1);
    chk("issue_opcode", {27'd0, opcode}, {27'd0, data[15:11]});
    chk("issue_instr", {16'd0, instr}, {16'd0, data});
    chk("issue_noreq", {31'd0, imem_req}, 32'd0);
  endtask

  // Retire the issued instruction after stall cycles; model updated, DUT checked.
  task automatic retire(input logic [15:0] ins, input int stall, input logic [4:0] jmp,
                        input logic fw, input logic [2:0] alu);
    bit taken;
    for (int i = 0; i < stall; i++) begin
      ex_ready = 1'b0;
      {is_jump, is_jz, is_jnz, is_jl, is_jg} = 5'($urandom);
      step();
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_opcode", {27'd0, opcode}, {27'd0, ins[15:11]});
      chk("stall_pc", {24'd0, pc}, m_pc[31:0] & 32'hFF);
      chk("stall_noreq", {31'd0, imem_req}, 32'd0);
    end
    {is_jump, is_jz, is_jnz, is_jl, is_jg} = jmp;
    flags_write = fw; {alu_zero, alu_neg, alu_pos} = alu;
    ex_ready = 1'b1;
    step();
    ex_ready = 1'b0; {is_jump, is_jz, is_jnz, is_jl, is_jg} = '0; flags_write = 1'b0;
    taken = jmp[4] || (jmp[3] && m_z) || (jmp[2] && !m_z) || (jmp[1] && m_l) || (jmp[0] && m_g);
    m_pc = taken ? int'(ins[7:0]) : (m_pc + 1) % 256;
    if (fw) begin m_z = alu[2]; m_l = alu[1]; m_g = alu[0]; end
    m_count++;
    chk("ret_pc", {24'd0, pc}, m_pc[31:0]);
    chk("ret_flags", {29'd0, flag_z, flag_l, flag_g}, {29'd0, m_z, m_l, m_g});
    chk("ret_valid", {31'd0, instr_valid}, 32'd0);
    chk("ret_halted", {31'd0, halted}, {31'd0, ins[15:11] == 5'b11111});
`ifdef FETCH_RETIRE_COUNT_EN
    chk("retire_count", retire_count, m_count[31:0]);
`endif
  endtask

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // {ins, lat, stall, jmp, fw, alu, exp_pc, exp_flags}
    tbl.push_back('{16'h0805, 2, 0, 5'b00000, 1'b0, 3'b000, 8'h01, 3'b000});
    tbl.push_back('{16'h1000, 0, 4, 5'b00000, 1'b1, 3'b100, 8'h02, 3'b100});
    tbl.push_back('{16'h2040, 1, 0, 5'b01000, 1'b0, 3'b000, 8'h40, 3'b100});
    tbl.push_back('{16'h1111, 0, 1, 5'b00000, 1'b1, 3'b001, 8'h41, 3'b001});
    tbl.push_back('{16'h2077, 3, 0, 5'b01000, 1'b0, 3'b000, 8'h42, 3'b001});
    tbl.push_back('{16'h2099, 0, 0, 5'b01000, 1'b1, 3'b100, 8'h43, 3'b100});
    tbl.push_back('{16'h30FF, 1, 0, 5'b00010, 1'b0, 3'b000, 8'h44, 3'b100});
    tbl.push_back('{16'h0000, 0, 2, 5'b00000, 1'b1, 3'b010, 8'h45, 3'b010});
    tbl.push_back('{16'h30FF, 2, 0, 5'b00010, 1'b0, 3'b000, 8'hFF, 3'b010});
    tbl.push_back('{16'h0000, 0, 0, 5'b00000, 1'b0, 3'b000, 8'h00, 3'b010});
    tbl.push_back('{16'h4012, 1, 0, 5'b00101, 1'b0, 3'b000, 8'h12, 3'b010});

    // Reset state
    repeat (2) step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_flags", {29'd0, flag_z, flag_l, flag_g}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'd0);
`ifdef FETCH_RETIRE_COUNT_EN
    chk("rst_count", retire_count, 32'd0);
`endif
    model_reset();
    rst_n = 1'b1;
    step();
    chk("first_edge_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", {24'd0, imem_addr}, 32'd0);

    // Directed table
    foreach (tbl[i]) begin
      fetch(tbl[i].ins, tbl[i].lat);
      retire(tbl[i].ins, tbl[i].stall, tbl[i].jmp, tbl[i].fw, tbl[i].alu);
      chk($sformatf("tbl%0d_pc", i), {24'd0, pc}, {24'd0, tbl[i].exp_pc});
      chk($sformatf("tbl%0d_flags", i), {29'd0, flag_z, flag_l, flag_g}, {29'd0, tbl[i].exp_flags});
    end

    // Halt: PC advances once, then fetching stops for good
    fetch(16'hF8AB, 0);
    retire(16'hF8AB, 0, 5'b00000, 1'b0, 3'b000);
    chk("halt_pc", {24'd0, pc}, 32'h13);
    for (int i = 0; i < 20; i++) begin
      imem_ack = (i % 3 == 0);
      ex_ready = 1'b1;
      step();
      chk("halt_noreq", {31'd0, imem_req}, 32'd0);
      chk("halt_novalid", {31'd0, instr_valid}, 32'd0);
      chk("halt_pcfrozen", {24'd0, pc}, 32'h13);
      chk("halt_sticky", {31'd0, halted}, 32'd1);
    end
    imem_ack = 1'b0; ex_ready = 1'b0;

    // Async reset while waiting for an ack, then a stale ack
    apply_reset();
    fetch(16'h0801, 0);
    retire(16'h0801, 0, 5'b10000, 1'b0, 3'b000);
    step();
    step();
    chk("mid_req_up", {31'd0, imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_pc", {24'd0, pc}, 32'd0);
    chk("async_halted", {31'd0, halted}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 16'hFFFF;
    step();
    model_reset();
    rst_n = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("stale_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("stale_ack_instr", {16'd0, instr}, 32'd0);
    chk("stale_ack_req", {31'd0, imem_req}, 32'd1);
`ifdef FETCH_RETIRE_COUNT_EN
    chk("count_after_rst", retire_count, 32'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      fetch(16'h0100 + 16'(i), i);
      retire(16'h0100 + 16'(i), 0, 5'b00000, 1'b0, 3'b000);
    end
`ifdef FETCH_RETIRE_COUNT_EN
    chk("count_three", retire_count, 32'd3);
`endif

    // Random traffic against the model
    for (int n = 0; n < 80; n++) begin
      logic [15:0] ins;
      logic [4:0]  jmp;
      ins = 16'($urandom);
      if (ins[15:11] == 5'b11111) ins[15] = 1'b0;
      jmp = 5'($urandom);
      if ($urandom_range(3) != 0) jmp[4] = 1'b0;
      fetch(ins, int'($urandom_range(3)));
      retire(ins, int'($urandom_range(2)), jmp, 1'($urandom), 3'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front-end stage directly upstream of the main control unit. Owns the program counter, instruction fetch handshake, instruction register and the flags register.
- Presents the 5-bit opcode to the control unit. Consumes its is_jz/is_jnz/is_jl/is_jg/is_jump and flags_write outputs to select the next PC.
- Single-issue, non-pipelined: one instruction in flight at a time.

Parameters:
- ADDR_W, 8, PC and instruction-memory address width.
- INSTR_W, 16, instruction width; opcode = instr[INSTR_W-1:INSTR_W-5].
- RESET_PC, 0, PC value loaded on reset.
- HALT_OPCODE, 5'b11111, opcode that stops fetching.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request, held until imem_ack.
- imem_addr  out  ADDR_W  fetch address (= PC), stable while imem_req=1.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  INSTR_W  instruction word.
- opcode  out  5  IR opcode field to control unit.
- instr  out  INSTR_W  full IR to register file / immediate path.
- instr_valid  out  1  IR holds an instruction in ISSUE.
- ex_ready  in  1  execute stage accepts the instruction this cycle.
- is_jz, is_jnz, is_jl, is_jg, is_jump  in  1 each  branch decode from control unit.
- flags_write  in  1  control unit: update flags.
- alu_zero, alu_neg, alu_pos  in  1 each  ALU result flags.
- flag_z, flag_l, flag_g  out  1 each  registered flags.
- pc  out  ADDR_W  current PC.
- halted  out  1  HALT retired.

Behaviour:
- Reset (rst_n=0, async): state=FETCH_REQ, pc=RESET_PC, IR=0, flags=0, imem_req=0, instr_valid=0, halted=0. The first request is raised on the first clock edge after rst_n deasserts.
- State FETCH_REQ: drive imem_req=1, imem_addr=pc. Next cycle go to FETCH_WAIT.
- State FETCH_WAIT: hold imem_req=1 and the address.
  - On imem_ack=1: IR<=imem_rdata, imem_req<=0, go to ISSUE.
  - An ack arriving in the same cycle the request first rises is accepted; minimum fetch latency is 1 cycle.
- State ISSUE: instr_valid=1; opcode/instr driven from IR. The control-unit inputs are combinational from opcode and are sampled only when ex_ready=1.
  - ex_ready=0: hold everything; instr_valid stays 1.
  - ex_ready=1 (retire): apply the flag update and select the next PC as below, then go to FETCH_REQ, or HALTED if opcode==HALT_OPCODE.
- Flag update at retire, only if flags_write=1: flag_z<=alu_zero, flag_l<=alu_neg, flag_g<=alu_pos. Otherwise flags hold.
- Branch evaluation at retire uses the flag values registered before this instruction.
  - taken = is_jump | (is_jz & flag_z) | (is_jnz & ~flag_z) | (is_jl & flag_l) | (is_jg & flag_g).
  - Taken: pc <= instr[ADDR_W-1:0]. Not taken: pc <= pc+1, modulo 2^ADDR_W (wraps all-ones to 0 with no flag).
  - Multiple jump inputs high at once: OR as above; no error.
- State HALTED: imem_req=0, instr_valid=0, halted=1, pc frozen. Only reset exits.
- Reset mid-handshake, in any state: immediate return to reset values. A late imem_ack with no outstanding request is ignored.
- imem_ack outside FETCH_WAIT is ignored.

Optional Feature:
- Macro: FETCH_RETIRE_COUNT_EN.
- Defined: adds output port retire_count (32 bits). Reset to 0; +1 on every ISSUE retire, HALT included; wraps at 2^32.
- Not defined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset/first fetch: release rst_n, ack after 2 wait cycles with 16'h0805 -> imem_addr=0 during request; opcode=5'b00001, instr_valid=1; after ex_ready, pc=1 and new request at address 1.
- Execute stall: hold ex_ready=0 for 4 cycles in ISSUE -> instr_valid, opcode and pc stable; no imem_req; retire on the 5th cycle.
- Conditional branch: retire with flags_write=1, alu_zero=1, then an instruction with is_jz=1 and low byte 8'h40 -> flag_z=1, next imem_addr=8'h40. Repeat with alu_zero=0 -> next address is pc+1.
- Same-instruction flags vs branch: flag_z=0; an instruction with is_jz=1 and flags_write=1, alu_zero=1 -> not taken (old flag used); flag_z becomes 1 afterward.
- Wrap and halt: pc=8'hFF, non-branch retire -> pc=8'h00; then fetch opcode 5'b11111 and retire -> halted=1, imem_req stays 0 for 20 cycles.
- Async reset mid-fetch: pull rst_n low while in FETCH_WAIT, between edges -> imem_req drops immediately, pc=RESET_PC; a stale ack is ignored. With FETCH_RETIRE_COUNT_EN defined, retire_count=0 after reset and equals 3 after 3 retires.
